// File: rtl/dso_trigger_ctrl_if.sv
// Sample bus from the ADC plus the trigger handshake with adc_driver.
// trigger_req is a level: once raised it stays high until waiting_for_trigger drops.
interface dso_trigger_ctrl_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] adc_data;
    logic              sample_en;
    logic              waiting_for_trigger;
    logic              trigger_req;

    modport master (
        output adc_data,
        output sample_en,
        output waiting_for_trigger,
        input  trigger_req
    );

    modport slave (
        input  adc_data,
        input  sample_en,
        input  waiting_for_trigger,
        output trigger_req
    );
endinterface

// File: rtl/dso_trigger_ctrl.sv
// Trigger sequencer: holdoff, hysteresis arming, level/edge detection and AUTO timeout,
// raising trigger_req towards the acquisition driver while it waits for a trigger.
module dso_trigger_ctrl #(
    parameter int DATA_W = 8,
    parameter int TMO_W  = 24,
    parameter int HOLD_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    dso_trigger_ctrl_if.slave io_bus,
    input  logic [1:0]        i_mode,
    input  logic              i_edge_sel,
    input  logic [DATA_W-1:0] i_trig_level,
    input  logic [DATA_W-1:0] i_hysteresis,
    input  logic [HOLD_W-1:0] i_holdoff,
    input  logic [TMO_W-1:0]  i_auto_timeout,
    output logic              o_auto_fired,
    output logic [2:0]        o_seq_state,
    output logic [15:0]       o_trig_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HOLDOFF = 3'd1,
        S_ARM     = 3'd2,
        S_SEEK    = 3'd3,
        S_FIRE    = 3'd4
    } state_t;

    localparam logic [1:0]        MODE_AUTO = 2'd1;
    localparam logic [1:0]        MODE_IMM  = 2'd2;
    localparam logic [HOLD_W-1:0] HOLD_ONE  = 1;
    localparam logic [TMO_W-1:0]  TMO_ONE   = 1;
    localparam logic [15:0]       CNT_ONE   = 16'd1;

    state_t r_state;
    state_t w_next;

    logic [1:0]        r_mode_q;
    logic              r_edge_q;
    logic [DATA_W-1:0] r_level_q;
    logic [DATA_W-1:0] r_hyst_q;
    logic [HOLD_W-1:0] r_holdoff_q;
    logic [TMO_W-1:0]  r_tmo_q;

    logic [HOLD_W-1:0] r_hold_cnt;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic              r_trigger_req;
    logic              r_auto_fired;
    logic [15:0]       r_trig_count;

    logic              w_latch;
    logic              w_arm_entry;
    logic              w_fire_entry;
    logic              w_fire_auto;
    logic              w_hold_inc;
    logic              w_tmo_inc;
    logic              w_timeout;
    logic              w_arm_hit;
    logic              w_edge_hit;

    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W-1:0] w_hi;
    logic [DATA_W-1:0] w_lo;

    // Hysteresis band in one extra bit so the carry/borrow drives saturation.
    assign w_sum  = {1'b0, r_level_q} + {1'b0, r_hyst_q};
    assign w_diff = {1'b0, r_level_q} - {1'b0, r_hyst_q};
    assign w_hi   = w_sum[DATA_W]  ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
    assign w_lo   = w_diff[DATA_W] ? {DATA_W{1'b0}} : w_diff[DATA_W-1:0];

    assign w_arm_hit  = r_edge_q ? (io_bus.adc_data >= w_hi)
                                 : (io_bus.adc_data <= w_lo);
    assign w_edge_hit = r_edge_q ? (io_bus.adc_data <= r_level_q)
                                 : (io_bus.adc_data >= r_level_q);
    assign w_timeout  = (r_mode_q == MODE_AUTO) && (r_tmo_cnt == r_tmo_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_latch      = 1'b0;
        w_arm_entry  = 1'b0;
        w_fire_entry = 1'b0;
        w_fire_auto  = 1'b0;
        w_hold_inc   = 1'b0;
        w_tmo_inc    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io_bus.waiting_for_trigger) begin
                    w_latch = 1'b1;
                    if (i_mode == MODE_IMM) begin
                        w_next       = S_FIRE;
                        w_fire_entry = 1'b1;
                    end else begin
                        w_next = S_HOLDOFF;
                    end
                end
            end
            S_HOLDOFF: begin
                if (!io_bus.waiting_for_trigger) begin
                    w_next = S_IDLE;
                end else if (r_hold_cnt == r_holdoff_q) begin
                    w_next      = S_ARM;
                    w_arm_entry = 1'b1;
                end else begin
                    w_hold_inc = io_bus.sample_en;
                end
            end
            S_ARM: begin
                if (!io_bus.waiting_for_trigger) begin
                    w_next = S_IDLE;
                end else if (w_timeout) begin
                    w_next       = S_FIRE;
                    w_fire_entry = 1'b1;
                    w_fire_auto  = 1'b1;
                end else begin
                    w_tmo_inc = io_bus.sample_en;
                    if (io_bus.sample_en && w_arm_hit) begin
                        w_next = S_SEEK;
                    end
                end
            end
            S_SEEK: begin
                // A real edge takes priority over a coincident timeout.
                if (!io_bus.waiting_for_trigger) begin
                    w_next = S_IDLE;
                end else if (io_bus.sample_en && w_edge_hit) begin
                    w_next       = S_FIRE;
                    w_fire_entry = 1'b1;
                end else if (w_timeout) begin
                    w_next       = S_FIRE;
                    w_fire_entry = 1'b1;
                    w_fire_auto  = 1'b1;
                end else begin
                    w_tmo_inc = io_bus.sample_en;
                end
            end
            S_FIRE: begin
                if (!io_bus.waiting_for_trigger) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_q      <= '0;
            r_edge_q      <= 1'b0;
            r_level_q     <= '0;
            r_hyst_q      <= '0;
            r_holdoff_q   <= '0;
            r_tmo_q       <= '0;
            r_hold_cnt    <= '0;
            r_tmo_cnt     <= '0;
            r_trigger_req <= 1'b0;
            r_auto_fired  <= 1'b0;
            r_trig_count  <= '0;
        end else begin
            if (w_latch) begin
                r_mode_q    <= i_mode;
                r_edge_q    <= i_edge_sel;
                r_level_q   <= i_trig_level;
                r_hyst_q    <= i_hysteresis;
                r_holdoff_q <= i_holdoff;
                r_tmo_q     <= i_auto_timeout;
                r_hold_cnt  <= '0;
                r_tmo_cnt   <= '0;
            end else begin
                if (w_hold_inc) begin
                    r_hold_cnt <= r_hold_cnt + HOLD_ONE;
                end
                if (w_arm_entry) begin
                    r_tmo_cnt <= '0;
                end else if (w_tmo_inc && (r_tmo_cnt != {TMO_W{1'b1}})) begin
                    r_tmo_cnt <= r_tmo_cnt + TMO_ONE;
                end
            end

            if (w_fire_entry) begin
                r_trigger_req <= 1'b1;
                r_auto_fired  <= w_fire_auto;
                r_trig_count  <= r_trig_count + CNT_ONE;
            end else if ((r_state == S_FIRE) && !io_bus.waiting_for_trigger) begin
                r_trigger_req <= 1'b0;
            end
        end
    end

    assign io_bus.trigger_req = r_trigger_req;
    assign o_auto_fired       = r_auto_fired;
    assign o_seq_state        = r_state;
    assign o_trig_count       = r_trig_count;

endmodule

// File: tb/tb_dso_trigger_ctrl.sv
// Bench for dso_trigger_ctrl: directed scenarios plus randomized searches checked
// against a sample-indexed reference model of the trigger rules.
module tb_dso_trigger_ctrl;

    localparam int NONE = -99;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode;
    logic        edge_sel;
    logic [7:0]  trig_level;
    logic [7:0]  hysteresis;
    logic [15:0] holdoff;
    logic [23:0] auto_timeout;
    logic        auto_fired;
    logic [2:0]  seq_state;
    logic [15:0] trig_count;

    int          n_checks = 0;
    int          n_pass = 0;
    int          exp_cnt = 0;
    logic        exp_auto = 1'b0;
    logic [15:0] exp_q[$];
    logic [7:0]  smp[64];
    int          n_smp = 0;

    dso_trigger_ctrl_if #(.DATA_W(8)) bus ();

    dso_trigger_ctrl #(.DATA_W(8), .TMO_W(24), .HOLD_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .io_bus        (bus),
        .i_mode        (mode),
        .i_edge_sel    (edge_sel),
        .i_trig_level  (trig_level),
        .i_hysteresis  (hysteresis),
        .i_holdoff     (holdoff),
        .i_auto_timeout(auto_timeout),
        .o_auto_fired  (auto_fired),
        .o_seq_state   (seq_state),
        .o_trig_count  (trig_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One sample_en strobe; returns at the negedge after the consuming posedge.
    task automatic send_sample(input logic [7:0] d);
        bus.adc_data  = d;
        bus.sample_en = 1'b1;
        @(negedge clk);
        bus.sample_en = 1'b0;
    endtask

    task automatic do_search(input logic [1:0] md, input logic ed, input logic [7:0] lvl,
                             input logic [7:0] hy, input logic [15:0] ho, input logic [23:0] tm,
                             input int gap, output int idx, output int lat, output logic af,
                             output logic [15:0] cnt, output logic [2:0] fs,
                             output logic [2:0] es, output logic et);
        @(negedge clk);
        mode = md; edge_sel = ed; trig_level = lvl; hysteresis = hy;
        holdoff = ho; auto_timeout = tm;
        bus.waiting_for_trigger = 1'b1;
        idx = NONE; lat = 0; af = 1'b0; cnt = '0; fs = '0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) begin
                // Shadowed config: these changes must not affect the running search.
                mode = 2'($urandom_range(0, 3)); edge_sel = 1'($urandom_range(0, 1));
                trig_level = 8'($urandom); hysteresis = 8'($urandom);
                holdoff = 16'($urandom_range(0, 5)); auto_timeout = 24'($urandom_range(0, 3));
            end
            if (idx == NONE && bus.trigger_req) begin
                idx = -1; lat = k; af = auto_fired; cnt = trig_count; fs = seq_state;
            end
        end
        for (int i = 0; i < n_smp; i++) begin
            if (idx != NONE) break;
            send_sample(smp[i]);
            if (bus.trigger_req) begin
                idx = i; lat = 1; af = auto_fired; cnt = trig_count; fs = seq_state;
            end
            for (int g = 1; g <= gap; g++) begin
                if (idx != NONE) break;
                @(negedge clk);
                if (bus.trigger_req) begin
                    idx = i; lat = g + 1; af = auto_fired; cnt = trig_count; fs = seq_state;
                end
            end
        end
        if (idx == NONE) begin
            af = auto_fired; cnt = trig_count; fs = seq_state;
        end
        bus.waiting_for_trigger = 1'b0;
        @(negedge clk);
        @(negedge clk);
        es = seq_state;
        et = bus.trigger_req;
    endtask

    // Reference: walks the sample list by index; timeout fires one cycle after the
    // tm-th counted sample, an edge fires one cycle after its own sample.
    task automatic model(input logic [1:0] md, input logic ed, input logic [7:0] lvl,
                         input logic [7:0] hy, input int ho, input int tm,
                         output int idx, output int lat, output logic af);
        int lo, hi, s, j;
        bit armed, is_auto;
        lo = int'(lvl) - int'(hy); if (lo < 0) lo = 0;
        hi = int'(lvl) + int'(hy); if (hi > 255) hi = 255;
        idx = NONE; lat = 0; af = 1'b0; armed = 0;
        is_auto = (md == 2'd1);
        if (md == 2'd2) begin
            idx = -1; lat = 1; af = 1'b0;
            return;
        end
        for (int i = 0; i < n_smp; i++) begin
            if (i < ho) continue;
            j = i - ho;
            s = int'(smp[i]);
            if (armed && (ed ? (s <= int'(lvl)) : (s >= int'(lvl)))) begin
                idx = i; lat = 1; af = 1'b0;
                return;
            end
            if (!armed && (ed ? (s >= hi) : (s <= lo))) armed = 1;
            if (is_auto && (j + 1 == tm)) begin
                idx = i; lat = 2; af = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (seq_state !== 3'd0 || bus.trigger_req !== 1'b0 || auto_fired !== 1'b0 || trig_count !== 16'd0) begin
            $display("FAIL reset_state: state=%0d req=%0b auto=%0b cnt=%0d expected 0/0/0/0",
                     seq_state, bus.trigger_req, auto_fired, trig_count);
        end else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (seq_state !== 3'd0 || bus.trigger_req !== 1'b0) begin
            $display("FAIL reset_idle: state=%0d req=%0b expected 0/0", seq_state, bus.trigger_req);
        end else n_pass++;
    endtask

    task automatic test_rising_ramp();
        int idx, lat; logic af; logic [15:0] cnt; logic [2:0] fs, es; logic et;
        n_smp = 49;
        for (int i = 0; i < 49; i++) smp[i] = 8'(8'h60 + i);
        do_search(2'd0, 1'b0, 8'h80, 8'h10, 16'd0, 24'd0, 2, idx, lat, af, cnt, fs, es, et);
        exp_cnt++; exp_auto = 1'b0;
        n_checks++;
        if (idx !== 32 || lat !== 1) $display("FAIL ramp_timing: idx=%0d lat=%0d expected 32/1", idx, lat);
        else n_pass++;
        n_checks++;
        if (af !== 1'b0 || cnt !== 16'(exp_cnt) || fs !== 3'd4)
            $display("FAIL ramp_status: auto=%0b cnt=%0d state=%0d expected 0/%0d/4", af, cnt, fs, exp_cnt);
        else n_pass++;
        n_checks++;
        if (es !== 3'd0 || et !== 1'b0) $display("FAIL ramp_release: state=%0d req=%0b expected 0/0", es, et);
        else n_pass++;
    endtask

    task automatic test_auto_timeout();
        int idx, lat; logic af; logic [15:0] cnt; logic [2:0] fs, es; logic et;
        n_smp = 20;
        for (int i = 0; i < 20; i++) smp[i] = 8'h7F;
        do_search(2'd0, 1'b0, 8'h80, 8'h10, 16'd0, 24'd5, 2, idx, lat, af, cnt, fs, es, et);
        n_checks++;
        if (idx !== NONE || cnt !== 16'(exp_cnt) || es !== 3'd0)
            $display("FAIL norm_no_trigger: idx=%0d cnt=%0d state=%0d expected none/%0d/0", idx, cnt, es, exp_cnt);
        else n_pass++;
        do_search(2'd1, 1'b0, 8'h80, 8'h10, 16'd0, 24'd5, 2, idx, lat, af, cnt, fs, es, et);
        exp_cnt++; exp_auto = 1'b1;
        n_checks++;
        if (idx !== 4 || lat !== 2) $display("FAIL auto_timing: idx=%0d lat=%0d expected 4/2", idx, lat);
        else n_pass++;
        n_checks++;
        if (af !== 1'b1 || cnt !== 16'(exp_cnt))
            $display("FAIL auto_status: auto=%0b cnt=%0d expected 1/%0d", af, cnt, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_immediate();
        int idx, lat; logic af; logic [15:0] cnt; logic [2:0] fs, es; logic et;
        n_smp = 1; smp[0] = 8'h00;
        do_search(2'd2, 1'b0, 8'h80, 8'h10, 16'd3, 24'd5, 2, idx, lat, af, cnt, fs, es, et);
        exp_cnt++; exp_auto = 1'b0;
        n_checks++;
        if (idx !== -1 || lat !== 1 || fs !== 3'd4)
            $display("FAIL immediate_timing: idx=%0d lat=%0d state=%0d expected -1/1/4", idx, lat, fs);
        else n_pass++;
        n_checks++;
        if (af !== 1'b0 || cnt !== 16'(exp_cnt))
            $display("FAIL immediate_status: auto=%0b cnt=%0d expected 0/%0d", af, cnt, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_edge_vs_timeout();
        int idx, lat; logic af; logic [15:0] cnt; logic [2:0] fs, es; logic et;
        n_smp = 1; smp[0] = 8'h7F;
        do_search(2'd1, 1'b0, 8'h80, 8'h10, 16'd0, 24'd0, 2, idx, lat, af, cnt, fs, es, et);
        exp_cnt++; exp_auto = 1'b1;
        n_checks++;
        if (idx !== -1 || lat !== 3 || af !== 1'b1)
            $display("FAIL timeout_zero: idx=%0d lat=%0d auto=%0b expected -1/3/1", idx, lat, af);
        else n_pass++;
        n_smp = 2; smp[0] = 8'h00; smp[1] = 8'h90;
        do_search(2'd1, 1'b0, 8'h80, 8'h10, 16'd0, 24'd1, 0, idx, lat, af, cnt, fs, es, et);
        exp_cnt++; exp_auto = 1'b0;
        n_checks++;
        if (idx !== 1 || lat !== 1 || af !== 1'b0 || cnt !== 16'(exp_cnt))
            $display("FAIL edge_wins: idx=%0d lat=%0d auto=%0b cnt=%0d expected 1/1/0/%0d", idx, lat, af, cnt, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_saturation();
        int idx, lat; logic af; logic [15:0] cnt; logic [2:0] fs, es; logic et;
        n_smp = 4; smp[0] = 8'h2F; smp[1] = 8'h10; smp[2] = 8'h30; smp[3] = 8'h10;
        do_search(2'd0, 1'b1, 8'h10, 8'h20, 16'd0, 24'd0, 2, idx, lat, af, cnt, fs, es, et);
        exp_cnt++;
        n_checks++;
        if (idx !== 3 || lat !== 1) $display("FAIL fall_hi_30: idx=%0d lat=%0d expected 3/1", idx, lat);
        else n_pass++;
        smp[0] = 8'h20; smp[1] = 8'h05; smp[2] = 8'hFF; smp[3] = 8'hF0;
        do_search(2'd0, 1'b1, 8'hF0, 8'h20, 16'd0, 24'd0, 2, idx, lat, af, cnt, fs, es, et);
        exp_cnt++;
        n_checks++;
        if (idx !== 3 || lat !== 1) $display("FAIL fall_hi_ff: idx=%0d lat=%0d expected 3/1", idx, lat);
        else n_pass++;
        smp[0] = 8'h50; smp[1] = 8'h20; smp[2] = 8'h00; smp[3] = 8'h08;
        do_search(2'd0, 1'b0, 8'h08, 8'h20, 16'd0, 24'd0, 2, idx, lat, af, cnt, fs, es, et);
        exp_cnt++;
        n_checks++;
        if (idx !== 3 || lat !== 1 || cnt !== 16'(exp_cnt))
            $display("FAIL rise_lo_00: idx=%0d lat=%0d cnt=%0d expected 3/1/%0d", idx, lat, cnt, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_holdoff();
        int idx, lat; logic af; logic [15:0] cnt; logic [2:0] fs, es; logic et;
        n_smp = 6;
        smp[0] = 8'h00; smp[1] = 8'h90; smp[2] = 8'h90;
        smp[3] = 8'h00; smp[4] = 8'h50; smp[5] = 8'h90;
        do_search(2'd0, 1'b0, 8'h80, 8'h10, 16'd3, 24'd0, 2, idx, lat, af, cnt, fs, es, et);
        exp_cnt++;
        n_checks++;
        if (idx !== 5 || lat !== 1 || cnt !== 16'(exp_cnt))
            $display("FAIL holdoff_3: idx=%0d lat=%0d cnt=%0d expected 5/1/%0d", idx, lat, cnt, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_abort();
        bit seen_req = 0;
        @(negedge clk);
        mode = 2'd0; edge_sel = 1'b0; trig_level = 8'h80; hysteresis = 8'h10;
        holdoff = 16'd0; auto_timeout = 24'd2;
        bus.waiting_for_trigger = 1'b1;
        repeat (3) @(negedge clk);
        send_sample(8'h00);
        @(negedge clk);
        send_sample(8'h50);
        seen_req = seen_req | bus.trigger_req;
        n_checks++;
        if (seq_state !== 3'd3) $display("FAIL abort_in_seek: state=%0d expected 3", seq_state);
        else n_pass++;
        bus.waiting_for_trigger = 1'b0;
        @(negedge clk);
        seen_req = seen_req | bus.trigger_req;
        n_checks++;
        if (seq_state !== 3'd0) $display("FAIL abort_idle: state=%0d expected 0", seq_state);
        else n_pass++;
        send_sample(8'h90);
        @(negedge clk);
        seen_req = seen_req | bus.trigger_req;
        n_checks++;
        if (seen_req || trig_count !== 16'(exp_cnt) || seq_state !== 3'd0)
            $display("FAIL abort_no_trigger: req_seen=%0b cnt=%0d state=%0d expected 0/%0d/0",
                     seen_req, trig_count, seq_state, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        int idx, lat, e_idx, e_lat; logic af, e_af; logic [15:0] cnt; logic [2:0] fs, es; logic et;
        logic [1:0] md; logic ed; logic [7:0] lvl, hy; int ho, tm;
        int bad = 0;
        for (int t = 0; t < 40; t++) begin
            md = 2'($urandom_range(0, 3)); ed = 1'($urandom_range(0, 1));
            lvl = 8'($urandom_range(32, 224)); hy = 8'($urandom_range(0, 48));
            ho = $urandom_range(0, 4); tm = $urandom_range(1, 12);
            n_smp = 20;
            for (int i = 0; i < 20; i++) smp[i] = 8'($urandom_range(0, 255));
            model(md, ed, lvl, hy, ho, tm, e_idx, e_lat, e_af);
            do_search(md, ed, lvl, hy, 16'(ho), 24'(tm), 2, idx, lat, af, cnt, fs, es, et);
            if (e_idx != NONE) begin
                exp_cnt++; exp_auto = e_af;
            end
            exp_q.push_back(16'(exp_cnt));
            n_checks++;
            if (idx !== e_idx || lat !== e_lat) begin
                $display("FAIL rand_timing[%0d]: idx=%0d lat=%0d expected %0d/%0d", t, idx, lat, e_idx, e_lat);
                bad++;
            end else n_pass++;
            n_checks++;
            if (af !== exp_auto || cnt !== exp_q.pop_front()) begin
                $display("FAIL rand_status[%0d]: auto=%0b cnt=%0d expected %0b/%0d", t, af, cnt, exp_auto, exp_cnt);
                bad++;
            end else n_pass++;
            n_checks++;
            if (es !== 3'd0 || et !== 1'b0) begin
                $display("FAIL rand_release[%0d]: state=%0d req=%0b expected 0/0", t, es, et);
                bad++;
            end else n_pass++;
            if (bad > 10) break;
        end
    endtask

    task automatic test_reset_in_fire();
        @(negedge clk);
        mode = 2'd2;
        bus.waiting_for_trigger = 1'b1;
        @(negedge clk);
        exp_cnt++;
        n_checks++;
        if (bus.trigger_req !== 1'b1 || seq_state !== 3'd4)
            $display("FAIL fire_before_reset: req=%0b state=%0d expected 1/4", bus.trigger_req, seq_state);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.trigger_req !== 1'b0 || seq_state !== 3'd0 || trig_count !== 16'd0 || auto_fired !== 1'b0)
            $display("FAIL async_reset: req=%0b state=%0d cnt=%0d auto=%0b expected 0/0/0/0",
                     bus.trigger_req, seq_state, trig_count, auto_fired);
        else n_pass++;
        bus.waiting_for_trigger = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0; exp_auto = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (seq_state !== 3'd0 || bus.trigger_req !== 1'b0)
            $display("FAIL post_reset_idle: state=%0d req=%0b expected 0/0", seq_state, bus.trigger_req);
        else n_pass++;
    endtask

    initial begin
        bus.adc_data = '0; bus.sample_en = 1'b0; bus.waiting_for_trigger = 1'b0;
        mode = '0; edge_sel = 1'b0; trig_level = '0; hysteresis = '0;
        holdoff = '0; auto_timeout = '0;
        @(negedge clk);
        test_reset();
        test_rising_ramp();
        test_auto_timeout();
        test_immediate();
        test_edge_vs_timeout();
        test_saturation();
        test_holdoff();
        test_abort();
        test_random();
        test_reset_in_fire();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
